plic_gw: RTL and testbench
==========================

// Module: plic_gw
// PURPOSE
// - Next-generation platform-level interrupt controller (base 0x50000000) with gateways, pending, arbitration, claim/complete.
// - Parametrised in source count, context count and priority width.
// - Sits between device IRQ lines and the per-hart external-interrupt inputs (mip.MEIP/SEIP).
// - Drives one registered interrupt line per context.
// PARAMETERS
// - N_CTX       2   number of contexts (hart privilege targets)
// - N_INT_SRC   32  interrupt IDs 0..N_INT_SRC-1; ID 0 reserved, never pends; max 1024
// - W_INT_PRIO  3   priority/threshold width; 0 = never interrupts
// PORTS
// - CLK        in   1          clock
// - RST_X      in   1          asynchronous active-low reset
// - w_offset   in   30         byte offset from base
// - w_we       in   1          register write strobe
// - w_wdata    in   32         write data
// - w_re       in   1          register read strobe (claim side effect)
// - w_rdata    out  32         read data, registered
// - w_int_src  in   N_INT_SRC  device IRQ lines, synchronous to CLK; bit 0 ignored
// - w_eip      out  N_CTX      per-context interrupt pending to hart, registered
// BEHAVIOUR
// - Map: priority[id] @4*id; pending word k @0x1000+4k (RO); enable ctx c word k @0x2000+0x80c+4k;
//   threshold @0x200000+0x1000c; claim/complete @0x200004+0x1000c. Unmapped: read 0, write ignored.
// - Reset: all priority/enable/threshold/pending 0, gateways IDLE, w_eip=0, w_rdata=0.
// - Widths: priority/threshold writes keep low W_INT_PRIO bits, read zero-extended; enable bit 0 and bits >=N_INT_SRC read 0.
// - Gateway per ID, states IDLE/PEND/CLAIMED:
//   IDLE->PEND when w_int_src[id]=1; PEND->CLAIMED on a claim returning id;
//   CLAIMED->IDLE on complete write (w_wdata=id) to any ctx claim reg; complete for id not CLAIMED, id 0 or id>=N_INT_SRC ignored.
//   Complete while source still high: IDLE this edge, PEND next edge.
// - Pending bit = gateway in PEND.
// - Arbitration, per ctx each cycle over pending&enable with priority>threshold:
//   highest priority wins; tie -> lowest ID. Result registered as r_best_id[c] (0 if none).
// - w_eip[c] = (r_best_id[c]!=0), registered.
// - Latency: src rises edge N -> pending N+1 -> best/w_eip N+2.
// - Read: w_rdata updated the edge after w_re (1-cycle latency), else holds 0.
// - Claim (w_re @ claim c): returns r_best_id[c] only if that ID is still PEND and enabled for c at that edge, else returns 0.
//   Non-zero claim moves gateway to CLAIMED on the same edge; claim of 0 has no side effect.
// - w_we and w_re in the same cycle: both act; read returns pre-write value.
// - Threshold/priority/enable change: w_eip reflects it 2 edges after the write.
// - Reset mid-operation: asynchronous; all state returns to reset values immediately.
// CONFIGURATION
// - PLIC_EDGE_TRIG_EN defined:
//   gateways edge-triggered; per-source r_src_d register; rising edge (src & ~src_d) sets PEND.
//   Edge during PEND is merged. Edge during CLAIMED sets a 1-deep r_edge_held, which re-pends on complete; further edges lost.
//   Level held high after complete does not re-pend.
// - PLIC_EDGE_TRIG_EN undefined: level-triggered as above; no src_d / edge_held flops.
// TESTING
// - Reset: RST_X low mid-traffic -> w_eip=0, w_rdata=0, all reg reads 0 immediately after release.
// - Basic: prio[5]=3, en ctx0 bit5, thr0=1, src5 high at edge N -> pending word0=0x20 at N+1, w_eip[0]=1 at N+2, claim0 reads 5.
// - Basic (cont.): after claim, w_eip[0]=0 two edges later; complete 5 with src5 still high -> re-pends, w_eip[0]=1 again.
// - Arbitration: ids 3,7 prio 2; id 9 prio 1; all pending, enabled ctx1 -> claims return 3, 7, 9, then 0.
// - Threshold: thr1=2 with only id 9 (prio 1) pending -> w_eip[1]=0; thr1=0 -> w_eip[1]=1 two edges later.
// - Stale claim: disable id 5 then claim on next cycle -> returns 0, gateway stays PEND.
// - Bad complete: complete id 0, id 40 and unclaimed id 6 -> no state change.
// - Edge (PLIC_EDGE_TRIG_EN): src pulse 1 cycle -> pends.
// - Edge (cont.): second pulse while CLAIMED -> re-pends after complete; third pulse in same window lost.

Source files
------------

// File: rtl/plic_gw.sv
// plic_gw: platform-level interrupt controller with per-source gateways, pending
// tracking, per-context priority arbitration and claim/complete handshake.
// Build macro PLIC_EDGE_TRIG_EN selects edge-triggered gateways (default: level).
module plic_gw #(
  parameter int unsigned N_CTX      = 2,
  parameter int unsigned N_INT_SRC  = 32,
  parameter int unsigned W_INT_PRIO = 3
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic [29:0]          w_offset,
  input  logic                 w_we,
  input  logic [31:0]          w_wdata,
  input  logic                 w_re,
  output logic [31:0]          w_rdata,
  input  logic [N_INT_SRC-1:0] w_int_src,
  output logic [N_CTX-1:0]     w_eip
);

  localparam int unsigned W_ID   = (N_INT_SRC > 1) ? $clog2(N_INT_SRC) : 1;
  localparam int unsigned N_WORD = (N_INT_SRC + 31) / 32;
  localparam int unsigned W_PAD  = N_WORD * 32;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PEND    = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

  gw_state_e             r_gw      [N_INT_SRC];
  gw_state_e             gw_d      [N_INT_SRC];
  logic [W_INT_PRIO-1:0] r_prio    [N_INT_SRC];
  logic [N_INT_SRC-1:0]  r_en      [N_CTX];
  logic [N_INT_SRC-1:0]  en_d      [N_CTX];
  logic [W_INT_PRIO-1:0] r_thr     [N_CTX];
  logic [W_ID-1:0]       r_best_id [N_CTX];
  logic [W_ID-1:0]       best_id_c [N_CTX];
  logic [W_INT_PRIO-1:0] best_prio [N_CTX];

  logic [31:0]          addr, rel_en, rel_ctx, pend_word, en_ctx, en_word, t_ctx;
  logic                 sel_prio, sel_pend, sel_en, sel_thr, sel_claim, in_ctx;
  logic [W_ID-1:0]      a_id, claim_id_c, cmp_id;
  logic                 claim_hit, cmp_hit;
  logic [N_INT_SRC-1:0] pend_c, trig_c;
  logic [W_PAD-1:0]     en_pad, en_rd_pad, pend_pad;
  logic [31:0]          rdata_c;

`ifdef PLIC_EDGE_TRIG_EN
  logic [N_INT_SRC-1:0] r_src_d, r_edge_held, held_d;
  assign trig_c = w_int_src & ~r_src_d;
`else
  assign trig_c = w_int_src;
`endif

  // Register map decode of the byte offset
  always_comb begin
    addr      = {2'b00, w_offset};
    rel_en    = addr - 32'h0000_2000;
    rel_ctx   = addr - 32'h0020_0000;
    a_id      = W_ID'(addr >> 2);
    pend_word = (addr - 32'h0000_1000) >> 2;
    en_ctx    = rel_en >> 7;
    en_word   = 32'(rel_en[6:2]);
    t_ctx     = rel_ctx >> 12;
    sel_prio  = (addr[1:0] == 2'b00) && (addr < 32'(4 * N_INT_SRC));
    sel_pend  = (addr[1:0] == 2'b00) && (addr >= 32'h1000) &&
                (addr < 32'h1000 + 32'(4 * N_WORD));
    sel_en    = (addr[1:0] == 2'b00) && (addr >= 32'h2000) &&
                (addr < 32'h2000 + 32'(128 * N_CTX)) && (en_word < 32'(N_WORD));
    in_ctx    = (addr >= 32'h0020_0000) && (addr < 32'h0020_0000 + 32'(4096 * N_CTX));
    sel_thr   = in_ctx && (rel_ctx[11:0] == 12'h000);
    sel_claim = in_ctx && (rel_ctx[11:0] == 12'h004);
  end

  // Pending vector, claim result (still pending and enabled) and complete decode
  always_comb begin
    for (int i = 0; i < N_INT_SRC; i++) pend_c[i] = (r_gw[i] == GW_PEND);
    claim_id_c = '0;
    for (int c = 0; c < N_CTX; c++)
      if ((t_ctx == 32'(c)) && (r_best_id[c] != '0) &&
          pend_c[r_best_id[c]] && r_en[c][r_best_id[c]])
        claim_id_c = r_best_id[c];
    claim_hit = w_re && sel_claim && (claim_id_c != '0);
    cmp_hit   = w_we && sel_claim && (w_wdata != 32'd0) && (w_wdata < 32'(N_INT_SRC));
    cmp_id    = W_ID'(w_wdata);
  end

  // Per-context arbitration: highest priority above threshold, ties to lowest ID
  always_comb begin
    for (int c = 0; c < N_CTX; c++) begin
      best_prio[c] = r_thr[c];
      best_id_c[c] = '0;
      for (int i = 1; i < N_INT_SRC; i++)
        if (pend_c[i] && r_en[c][i] && (r_prio[i] > best_prio[c])) begin
          best_prio[c] = r_prio[i];
          best_id_c[c] = W_ID'(i);
        end
    end
  end

  // Gateway next-state logic
  always_comb begin
    for (int i = 0; i < N_INT_SRC; i++) gw_d[i] = r_gw[i];
`ifdef PLIC_EDGE_TRIG_EN
    held_d = r_edge_held;
`endif
    for (int i = 0; i < N_INT_SRC; i++) begin
      case (r_gw[i])
        GW_IDLE:    if (trig_c[i] && (i != 0)) gw_d[i] = GW_PEND;
        GW_PEND:    if (claim_hit && (claim_id_c == W_ID'(i))) gw_d[i] = GW_CLAIMED;
        GW_CLAIMED: begin
          if (cmp_hit && (cmp_id == W_ID'(i))) begin
`ifdef PLIC_EDGE_TRIG_EN
            gw_d[i]   = (r_edge_held[i] || trig_c[i]) ? GW_PEND : GW_IDLE;
            held_d[i] = 1'b0;
`else
            gw_d[i] = GW_IDLE;
`endif
          end
`ifdef PLIC_EDGE_TRIG_EN
          else if (trig_c[i]) held_d[i] = 1'b1;
`endif
        end
        default:    gw_d[i] = GW_IDLE;
      endcase
    end
  end

  // Enable word merge for writes
  always_comb begin
    en_pad = '0;
    for (int c = 0; c < N_CTX; c++) begin
      en_pad = W_PAD'(r_en[c]);
      for (int w = 0; w < N_WORD; w++)
        if (w_we && sel_en && (en_ctx == 32'(c)) && (en_word == 32'(w)))
          en_pad[w*32 +: 32] = w_wdata;
      en_d[c] = N_INT_SRC'(en_pad) & ~N_INT_SRC'(1);
    end
  end

  // Read data mux (pre-write values)
  always_comb begin
    rdata_c   = '0;
    en_rd_pad = '0;
    pend_pad  = W_PAD'(pend_c);
    if (sel_prio) rdata_c = 32'(r_prio[a_id]);
    if (sel_pend)
      for (int w = 0; w < N_WORD; w++)
        if (pend_word == 32'(w)) rdata_c = pend_pad[w*32 +: 32];
    for (int c = 0; c < N_CTX; c++) begin
      en_rd_pad = W_PAD'(r_en[c]);
      if (sel_en && (en_ctx == 32'(c)))
        for (int w = 0; w < N_WORD; w++)
          if (en_word == 32'(w)) rdata_c = en_rd_pad[w*32 +: 32];
      if (sel_thr && (t_ctx == 32'(c))) rdata_c = 32'(r_thr[c]);
    end
    if (sel_claim) rdata_c = 32'(claim_id_c);
  end

  // Gateway state registers
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      for (int i = 0; i < N_INT_SRC; i++) r_gw[i] <= GW_IDLE;
`ifdef PLIC_EDGE_TRIG_EN
      r_src_d     <= '0;
      r_edge_held <= '0;
`endif
    end else begin
      for (int i = 0; i < N_INT_SRC; i++) r_gw[i] <= gw_d[i];
`ifdef PLIC_EDGE_TRIG_EN
      r_src_d     <= w_int_src;
      r_edge_held <= held_d;
`endif
    end
  end

  // Priority, enable and threshold registers
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      for (int i = 0; i < N_INT_SRC; i++) r_prio[i] <= '0;
      for (int c = 0; c < N_CTX; c++) begin
        r_en[c]  <= '0;
        r_thr[c] <= '0;
      end
    end else begin
      if (w_we && sel_prio && (a_id != '0)) r_prio[a_id] <= w_wdata[W_INT_PRIO-1:0];
      for (int c = 0; c < N_CTX; c++) begin
        r_en[c] <= en_d[c];
        if (w_we && sel_thr && (t_ctx == 32'(c))) r_thr[c] <= w_wdata[W_INT_PRIO-1:0];
      end
    end
  end

  // Registered arbitration winner and interrupt line per context
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      for (int c = 0; c < N_CTX; c++) r_best_id[c] <= '0;
      w_eip <= '0;
    end else begin
      for (int c = 0; c < N_CTX; c++) begin
        r_best_id[c] <= best_id_c[c];
        w_eip[c]     <= (best_id_c[c] != '0);
      end
    end
  end

  // Registered read data, zero when no read
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) w_rdata <= '0;
    else        w_rdata <= w_re ? rdata_c : 32'd0;
  end

endmodule

// File: tb/tb_plic_gw.sv
// tb_plic_gw: randomized + directed stimulus for plic_gw, checked by a scoreboard
// against a behavioural register/gateway model.
module tb_plic_gw;
  localparam int unsigned NC = 2;
  localparam int unsigned NS = 32;
  localparam int unsigned PW = 3;
  localparam int unsigned NW = (NS + 31) / 32;
  localparam int unsigned PMASK = (1 << PW) - 1;

  logic          CLK;
  logic          RST_X;
  logic [29:0]   off;
  logic          we, re;
  logic [31:0]   wdata;
  logic [31:0]   w_rdata;
  logic [NS-1:0] src;
  logic [NC-1:0] w_eip;

  plic_gw #(.N_CTX(NC), .N_INT_SRC(NS), .W_INT_PRIO(PW)) dut (
    .CLK(CLK), .RST_X(RST_X), .w_offset(off), .w_we(we), .w_wdata(wdata),
    .w_re(re), .w_rdata(w_rdata), .w_int_src(src), .w_eip(w_eip)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0]   rd;
    logic [NC-1:0] eip;
  } exp_t;
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // behavioural model state
  int unsigned prio_m [NS];
  bit          en_m   [NC][NS];
  int unsigned thr_m  [NC];
  bit          pend_m [NS];
  bit          clm_m  [NS];
  bit          held_m [NS];
  bit          srcd_m [NS];
  int unsigned best_m [NC];

  function automatic int unsigned PRIO(int unsigned id); return 4 * id; endfunction
  function automatic int unsigned EN(int unsigned c); return 32'h2000 + 32'h80 * c; endfunction
  function automatic int unsigned THR(int unsigned c); return 32'h200000 + 32'h1000 * c; endfunction
  function automatic int unsigned CLAIM(int unsigned c); return 32'h200004 + 32'h1000 * c; endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      prio_m[i] = 0; pend_m[i] = 0; clm_m[i] = 0; held_m[i] = 0; srcd_m[i] = 0;
      for (int c = 0; c < NC; c++) en_m[c][i] = 0;
    end
    for (int c = 0; c < NC; c++) begin thr_m[c] = 0; best_m[c] = 0; end
  endfunction

  function automatic int ctx_of_claim(int unsigned a);
    if (a >= 32'h200000 && a < 32'h200000 + 4096 * NC && (a - 32'h200000) % 4096 == 4)
      return int'((a - 32'h200000) / 4096);
    return -1;
  endfunction

  // scan priorities from the top down, lowest ID first within a level
  function automatic int unsigned best_for(int c);
    for (int p = int'(PMASK); p > int'(thr_m[c]); p--)
      for (int id = 1; id < int'(NS); id++)
        if (pend_m[id] && en_m[c][id] && prio_m[id] == 32'(p)) return 32'(id);
    return 0;
  endfunction

  function automatic logic [31:0] model_read(int unsigned a);
    logic [31:0] v;
    int unsigned c, k, r, id;
    v = '0;
    if (a % 4 != 0) return '0;
    if (a < 4 * NS) return prio_m[a / 4];
    if (a >= 32'h1000 && a < 32'h1000 + 4 * NW) begin
      k = (a - 32'h1000) / 4;
      for (int b = 0; b < 32; b++) begin
        id = k * 32 + 32'(b);
        if (id < NS && pend_m[id]) v[b] = 1'b1;
      end
      return v;
    end
    if (a >= 32'h2000 && a < 32'h2000 + 128 * NC) begin
      c = (a - 32'h2000) / 128;
      k = ((a - 32'h2000) % 128) / 4;
      if (k >= NW) return '0;
      for (int b = 0; b < 32; b++) begin
        id = k * 32 + 32'(b);
        if (id >= 1 && id < NS && en_m[c][id]) v[b] = 1'b1;
      end
      return v;
    end
    if (a >= 32'h200000 && a < 32'h200000 + 4096 * NC) begin
      c = (a - 32'h200000) / 4096;
      r = (a - 32'h200000) % 4096;
      if (r == 0) return thr_m[c];
      if (r == 4) begin
        k = best_m[c];
        if (k != 0 && pend_m[k] && en_m[c][k]) return k;
      end
    end
    return '0;
  endfunction

  function automatic void model_write(int unsigned a, logic [31:0] d);
    int unsigned c, k, id;
    if (a % 4 != 0) return;
    if (a < 4 * NS) begin
      if (a != 0) prio_m[a / 4] = d & PMASK;
    end else if (a >= 32'h2000 && a < 32'h2000 + 128 * NC) begin
      c = (a - 32'h2000) / 128;
      k = ((a - 32'h2000) % 128) / 4;
      if (k < NW)
        for (int b = 0; b < 32; b++) begin
          id = k * 32 + 32'(b);
          if (id >= 1 && id < NS) en_m[c][id] = d[b];
        end
    end else if (a >= 32'h200000 && a < 32'h200000 + 4096 * NC) begin
      c = (a - 32'h200000) / 4096;
      if ((a - 32'h200000) % 4096 == 0) thr_m[c] = d & PMASK;
    end
  endfunction

  // one clock edge of the reference model, using the inputs presented this cycle
  function automatic void model_step();
    int unsigned a, claim_id, cmp_id;
    int cc;
    logic [31:0] rdv;
    int unsigned nb [NC];
    bit p0 [NS];
    bit c0 [NS];
    bit idle, rise;
    exp_t e;
    a        = 32'(off);
    rdv      = re ? model_read(a) : 32'd0;
    cc       = ctx_of_claim(a);
    claim_id = (re && cc >= 0) ? rdv : 0;
    cmp_id   = 0;
    if (we && cc >= 0 && wdata >= 1 && wdata < NS)
      if (clm_m[wdata]) cmp_id = wdata;
    for (int c = 0; c < int'(NC); c++) nb[c] = best_for(c);
    p0 = pend_m;
    c0 = clm_m;
    for (int id = 1; id < int'(NS); id++) begin
      idle = !p0[id] && !c0[id];
      rise = src[id] && !srcd_m[id];
`ifdef PLIC_EDGE_TRIG_EN
      pend_m[id] = (p0[id] && 32'(id) != claim_id) || (idle && rise) ||
                   (c0[id] && 32'(id) == cmp_id && (held_m[id] || rise));
      held_m[id] = c0[id] && 32'(id) != cmp_id && (held_m[id] || rise);
`else
      pend_m[id] = (p0[id] && 32'(id) != claim_id) || (idle && src[id]);
`endif
      clm_m[id] = (c0[id] && 32'(id) != cmp_id) || (32'(id) == claim_id);
    end
    for (int id = 0; id < int'(NS); id++) srcd_m[id] = src[id];
    if (we) model_write(a, wdata);
    e.rd = rdv;
    for (int c = 0; c < int'(NC); c++) begin
      best_m[c] = nb[c];
      e.eip[c]  = (nb[c] != 0);
    end
    exp_q.push_back(e);
  endfunction

  // monitor: every cycle the DUT presents w_rdata and w_eip
  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (w_rdata !== e.rd) begin
        n_bad++;
        $display("FAIL rdata t=%0t got %h expected %h", $time, w_rdata, e.rd);
      end
      n_vec++;
      if (w_eip !== e.eip) begin
        n_bad++;
        $display("FAIL eip t=%0t got %b expected %b", $time, w_eip, e.eip);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(int unsigned a, logic [31:0] d);
    off = 30'(a); wdata = d; we = 1'b1; tick(); we = 1'b0;
  endtask

  task automatic rd(int unsigned a);
    off = 30'(a); re = 1'b1; tick(); re = 1'b0;
  endtask

  task automatic reset_mid();
    RST_X = 1'b0;
    exp_q.delete();
    #2;
    n_vec++;
    if (w_eip !== '0) begin n_bad++; $display("FAIL reset_eip got %b expected 0", w_eip); end
    n_vec++;
    if (w_rdata !== '0) begin n_bad++; $display("FAIL reset_rdata got %h expected 0", w_rdata); end
    model_reset();
    @(posedge CLK); #1;
    RST_X = 1'b1;
  endtask

  function automatic int unsigned rand_addr();
    case ($urandom_range(0, 9))
      0, 1: return 4 * $urandom_range(0, 35);
      2:    return 32'h1000 + 4 * $urandom_range(0, 1);
      3:    return 32'h2000 + 32'h80 * $urandom_range(0, 2) + 4 * $urandom_range(0, 1);
      4:    return THR($urandom_range(0, 2));
      5, 6: return CLAIM($urandom_range(0, 2));
      7:    return 32'h200008;
      8:    return 32'h2001 + $urandom_range(0, 2);
      default: return EN($urandom_range(0, 1));
    endcase
  endfunction

  initial begin
    int unsigned a, r;
    RST_X = 1'b0; off = '0; we = 1'b0; re = 1'b0; wdata = '0; src = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RST_X = 1'b1;

    // register reads out of reset
    rd(PRIO(5)); rd(32'h1000); rd(EN(0)); rd(EN(1)); rd(THR(0)); rd(CLAIM(1));

    // basic: one source through pend, claim, complete with line still high
    wr(PRIO(5), 3); wr(EN(0), 32'h20); wr(THR(0), 1);
    src[5] = 1'b1; tick();
    rd(32'h1000); idle(1);
    rd(CLAIM(0)); idle(3);
    wr(CLAIM(0), 5); idle(4);
    src[5] = 1'b0;
    rd(CLAIM(0)); wr(CLAIM(0), 5); idle(2);

    // arbitration on ctx1: two ties at prio 2 and one at prio 1
    wr(PRIO(3), 2); wr(PRIO(7), 2); wr(PRIO(9), 1);
    wr(EN(1), 32'h288); wr(THR(1), 0);
    src[3] = 1'b1; src[7] = 1'b1; src[9] = 1'b1; tick();
    src = '0; idle(3);
    for (int k = 0; k < 4; k++) begin rd(CLAIM(1)); idle(2); end
    wr(CLAIM(1), 3); wr(CLAIM(1), 7); wr(CLAIM(1), 9); idle(2);

    // threshold masks the only pending source, then unmasks it
    src[9] = 1'b1; tick(); src[9] = 1'b0;
    wr(THR(1), 2); idle(3);
    wr(THR(1), 0); idle(3);

    // stale claim after disabling
    src[5] = 1'b1; tick(); src[5] = 1'b0; idle(3);
    wr(EN(0), 0); rd(CLAIM(0)); rd(32'h1000);

    // bad completes are ignored
    wr(CLAIM(0), 0); wr(CLAIM(0), 40); wr(CLAIM(0), 6); rd(32'h1000);

    // simultaneous write and read of one register
    off = 30'(PRIO(5)); wdata = 6; we = 1'b1; re = 1'b1; tick(); we = 1'b0; re = 1'b0;
    rd(PRIO(5));

`ifdef PLIC_EDGE_TRIG_EN
    // edge gateway: pulse pends, second pulse held while claimed, third lost
    wr(PRIO(12), 4); wr(EN(0), 32'h1000); wr(THR(0), 0);
    src[12] = 1'b1; tick(); src[12] = 1'b0; idle(3);
    rd(CLAIM(0)); idle(2);
    src[12] = 1'b1; tick(); src[12] = 1'b0; tick();
    src[12] = 1'b1; tick(); src[12] = 1'b0; idle(2);
    rd(32'h1000); wr(CLAIM(0), 12); idle(3);
    rd(32'h1000); rd(CLAIM(0)); wr(CLAIM(0), 12); idle(3); rd(32'h1000);
`endif

    // randomized traffic, with a reset in the middle
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) begin
        reset_mid();
        rd(PRIO(3)); rd(32'h1000); rd(EN(1)); rd(THR(1)); rd(CLAIM(0));
      end
      if ($urandom_range(0, 99) < 10) src[$urandom_range(0, NS - 1)] ^= 1'b1;
      r = $urandom_range(0, 99);
      a = rand_addr();
      off = 30'(a); we = 1'b0; re = 1'b0; wdata = $urandom();
      if (r < 25) begin
      end else if (r < 50) begin
        we = 1'b1;
        if ($urandom_range(0, 3) == 0) re = 1'b1;
      end else if (r < 75) begin
        re = 1'b1;
      end else if (r < 88) begin
        off = 30'(CLAIM($urandom_range(0, 1))); we = 1'b1; wdata = $urandom_range(0, 40);
      end else begin
        off = 30'(CLAIM($urandom_range(0, 1))); re = 1'b1;
      end
      tick();
      we = 1'b0; re = 1'b0;
    end

    idle(3);
    @(negedge CLK); @(negedge CLK);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
